// File: rtl/ip_codma_read_machine_pkg.sv
// Shared types and helpers for the CODMA bus read engine.
package ip_codma_pkg;

    typedef logic [1:0] read_state_t;

    localparam read_state_t RD_IDLE    = 2'd0;
    localparam read_state_t RD_ASK     = 2'd1;
    localparam read_state_t RD_GRANTED = 2'd2;
    localparam read_state_t RD_ERROR   = 2'd3;

    localparam logic [7:0] SZ_1BEAT = 8'd3;
    localparam logic [7:0] SZ_2BEAT = 8'd8;
    localparam logic [7:0] SZ_4BEAT = 8'd9;

    typedef struct packed {
        logic       legal;
        logic [1:0] last_idx;   // number of beats minus one
    } beats_t;

    function automatic beats_t beats_of(input logic [7:0] size);
        beats_t b;
        b.legal    = 1'b1;
        b.last_idx = 2'd0;
        case (size)
            SZ_1BEAT: b.last_idx = 2'd0;
            SZ_2BEAT: b.last_idx = 2'd1;
            SZ_4BEAT: b.last_idx = 2'd3;
            default:  b.legal    = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ip_codma_read_machine_if.sv
// Memory-bus read channel between the CODMA read machine (master) and memory (slave).
interface ip_codma_read_machine_if;

    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [7:0]  bus_size_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [63:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_addr_o, bus_size_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_addr_o, bus_size_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

endinterface

// File: rtl/ip_codma_read_machine_rd_pack.sv
// Beat counter and packing of 64-bit read beats into the 8x32 data register.
module ip_codma_rd_pack (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             beat_i,
    input  logic [63:0]      data_i,
    input  logic [1:0]       last_idx_i,
    output logic [7:0][31:0] data_o,
    output logic             last_o
);

    logic [1:0]       cnt_q, cnt_d;
    logic [7:0][31:0] data_q, data_d;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_i) begin
            cnt_d  = 2'd0;
            data_d = '0;
        end else if (beat_i) begin
            data_d[{cnt_q, 1'b0}] = data_i[31:0];
            data_d[{cnt_q, 1'b1}] = data_i[63:32];
            cnt_d                 = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q  <= 2'd0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign last_o = (cnt_q == last_idx_i);

endmodule

// File: rtl/ip_codma_read_machine.sv
// CODMA bus read engine: single/burst read, beat packing, error reporting.
// Optional watchdog on RD_ASK/RD_GRANTED enabled by defining CODMA_RD_TIMEOUT_EN.
module ip_codma_read_machine
    import ip_codma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     need_read_i,
    input  logic [31:0]              reg_addr,
    input  logic [7:0]               reg_size,
    output logic                     need_read_o,
    output logic [7:0][31:0]         data_reg,
    output read_state_t              rd_state_r,
    output read_state_t              rd_state_next_s,
    output logic                     rd_state_error,
    ip_codma_read_machine_if.master  bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    read_state_t state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  size_q, size_d;
    logic [1:0]  last_idx_q, last_idx_d;
    logic        err_q, err_d;
    logic        clr;
    logic        beat_vld;
    logic        last_beat;
    logic        tmo_hit;
    logic        abort;
    beats_t      req_b;

    assign req_b    = beats_of(reg_size);
    assign abort    = bus.bus_err_i || tmo_hit;
    // An error in the same cycle as a beat wins: the beat is dropped.
    assign beat_vld = (state_q == RD_GRANTED) && bus.bus_rvalid_i && !abort;

`ifdef CODMA_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          busy;

    assign busy    = (state_q == RD_ASK) || (state_q == RD_GRANTED);
    assign tmo_hit = busy && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Any sign of bus progress restarts the watchdog.
    always_comb begin
        tmo_cnt_d = '0;
        if (busy && !((state_q == RD_ASK) && bus.bus_gnt_i) && !beat_vld)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) tmo_cnt_q <= '0;
        else            tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        size_d     = size_q;
        last_idx_d = last_idx_q;
        clr        = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (need_read_i) begin
                    if (req_b.legal) begin
                        state_d    = RD_ASK;
                        req_d      = 1'b1;
                        addr_d     = reg_addr;
                        size_d     = reg_size;
                        last_idx_d = req_b.last_idx;
                        clr        = 1'b1;
                    end else begin
                        state_d = RD_ERROR;
                    end
                end
            end
            RD_ASK: begin
                if (abort) begin
                    state_d = RD_ERROR;
                    req_d   = 1'b0;
                end else if (bus.bus_gnt_i) begin
                    state_d = RD_GRANTED;
                    req_d   = 1'b0;
                end
            end
            RD_GRANTED: begin
                req_d = 1'b0;
                if (abort)                       state_d = RD_ERROR;
                else if (beat_vld && last_beat)  state_d = RD_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = RD_IDLE;
            end
        endcase
        err_d = (state_d == RD_ERROR);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= RD_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            last_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            last_idx_q <= last_idx_d;
            err_q      <= err_d;
        end
    end

    ip_codma_rd_pack u_pack (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clear_i    (clr),
        .beat_i     (beat_vld),
        .data_i     (bus.bus_rdata_i),
        .last_idx_i (last_idx_q),
        .data_o     (data_reg),
        .last_o     (last_beat)
    );

    assign need_read_o     = (state_d != RD_IDLE);
    assign rd_state_r      = state_q;
    assign rd_state_next_s = state_d;
    assign rd_state_error  = err_q;
    assign bus.bus_req_o   = req_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_size_o  = size_q;

endmodule

// File: tb/tb_ip_codma_read_machine.sv
// Directed self-checking bench for the CODMA read machine.
module tb_ip_codma_read_machine;
    import ip_codma_pkg::*;

    localparam int TMO = 16;

    logic             clk_i = 1'b0;
    logic             reset_n_i = 1'b0;
    logic             need_read_i = 1'b0;
    logic [31:0]      reg_addr = '0;
    logic [7:0]       reg_size = '0;
    logic             need_read_o;
    logic [7:0][31:0] data_reg;
    read_state_t      rd_state_r;
    read_state_t      rd_state_next_s;
    logic             rd_state_error;
    logic [7:0][31:0] e;

    int n_tests = 0;
    int n_fail  = 0;

    ip_codma_read_machine_if bus ();

    ip_codma_read_machine #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .need_read_i     (need_read_i),
        .reg_addr        (reg_addr),
        .reg_size        (reg_size),
        .need_read_o     (need_read_o),
        .data_reg        (data_reg),
        .rd_state_r      (rd_state_r),
        .rd_state_next_s (rd_state_next_s),
        .rd_state_error  (rd_state_error),
        .bus             (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [7:0][31:0] exp);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(data_reg[i]), 64'(exp[i]));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.bus_gnt_i    = 1'b0;
        bus.bus_rvalid_i = 1'b0;
        bus.bus_rdata_i  = '0;
        bus.bus_err_i    = 1'b0;

        // Reset state
        #2;
        chk("rst_state", 64'(rd_state_r), 64'(RD_IDLE));
        chk("rst_req", 64'(bus.bus_req_o), 64'd0);
        chk("rst_addr", 64'(bus.bus_addr_o), 64'd0);
        chk("rst_size", 64'(bus.bus_size_o), 64'd0);
        chk("rst_err", 64'(rd_state_error), 64'd0);
        chk("rst_need", 64'(need_read_o), 64'd0);
        e = '0;
        chk_data("rst_data", e);
        #1 reset_n_i = 1'b1;
        tick();

        // Single beat, grant after 2 cycles
        need_read_i = 1'b1; reg_addr = 32'h1000; reg_size = 8'd3;
        settle();
        chk("t1_next_ask", 64'(rd_state_next_s), 64'(RD_ASK));
        chk("t1_need_hi", 64'(need_read_o), 64'd1);
        tick();
        chk("t1_ask", 64'(rd_state_r), 64'(RD_ASK));
        chk("t1_req", 64'(bus.bus_req_o), 64'd1);
        chk("t1_addr", 64'(bus.bus_addr_o), 64'h1000);
        chk("t1_size", 64'(bus.bus_size_o), 64'd3);
        reg_addr = 32'hFFFF_0000; reg_size = 8'd9;
        tick();
        chk("t1_ask2", 64'(rd_state_r), 64'(RD_ASK));
        chk("t1_addr_hold", 64'(bus.bus_addr_o), 64'h1000);
        chk("t1_size_hold", 64'(bus.bus_size_o), 64'd3);
        bus.bus_gnt_i = 1'b1;
        tick();
        bus.bus_gnt_i = 1'b0;
        chk("t1_granted", 64'(rd_state_r), 64'(RD_GRANTED));
        chk("t1_req_drop", 64'(bus.bus_req_o), 64'd0);
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 64'hDEADBEEF_01234567;
        settle();
        chk("t1_need_fall", 64'(need_read_o), 64'd0);
        chk("t1_next_idle", 64'(rd_state_next_s), 64'(RD_IDLE));
        need_read_i = 1'b0;
        tick();
        bus.bus_rvalid_i = 1'b0;
        chk("t1_idle", 64'(rd_state_r), 64'(RD_IDLE));
        e = '0; e[0] = 32'h01234567; e[1] = 32'hDEADBEEF;
        chk_data("t1_data", e);
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = '1;
        tick();
        bus.bus_rvalid_i = 1'b0;
        chk("t1_stray_idle", 64'(rd_state_r), 64'(RD_IDLE));
        chk_data("t1_stray_data", e);

        // Quad burst, rvalid with grant ignored
        need_read_i = 1'b1; reg_addr = 32'h2000; reg_size = 8'd9;
        tick();
        chk("t2_ask", 64'(rd_state_r), 64'(RD_ASK));
        chk("t2_addr", 64'(bus.bus_addr_o), 64'h2000);
        chk("t2_size", 64'(bus.bus_size_o), 64'd9);
        e = '0;
        chk_data("t2_clr", e);
        bus.bus_gnt_i = 1'b1; bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = '1;
        tick();
        bus.bus_gnt_i = 1'b0; bus.bus_rvalid_i = 1'b0;
        chk("t2_granted", 64'(rd_state_r), 64'(RD_GRANTED));
        chk_data("t2_ask_rv_ign", e);
        for (int k = 0; k < 4; k++) begin
            bus.bus_rvalid_i = 1'b1;
            bus.bus_rdata_i  = 64'h1_0000_0000 + 64'(k) * 64'h2_0000_0002;
            settle();
            if (k == 3) begin
                chk("t2_next_idle", 64'(rd_state_next_s), 64'(RD_IDLE));
                chk("t2_need_fall", 64'(need_read_o), 64'd0);
                need_read_i = 1'b0;
            end else begin
                chk($sformatf("t2_next_gr%0d", k), 64'(rd_state_next_s), 64'(RD_GRANTED));
            end
            tick();
            bus.bus_rvalid_i = 1'b0;
        end
        chk("t2_idle", 64'(rd_state_r), 64'(RD_IDLE));
        for (int i = 0; i < 8; i++) e[i] = 32'(i);
        chk_data("t2_data", e);

        // Illegal size
        need_read_i = 1'b1; reg_addr = 32'h7000; reg_size = 8'd5;
        settle();
        chk("t3_next_err", 64'(rd_state_next_s), 64'(RD_ERROR));
        tick();
        chk("t3_state_err", 64'(rd_state_r), 64'(RD_ERROR));
        chk("t3_err_hi", 64'(rd_state_error), 64'd1);
        chk("t3_no_req", 64'(bus.bus_req_o), 64'd0);
        chk("t3_addr_kept", 64'(bus.bus_addr_o), 64'h2000);
        reg_size = 8'd3;
        settle();
        chk("t3_no_accept", 64'(rd_state_next_s), 64'(RD_IDLE));
        tick();
        need_read_i = 1'b0;
        chk("t3_idle", 64'(rd_state_r), 64'(RD_IDLE));
        chk("t3_err_lo", 64'(rd_state_error), 64'd0);
        chk("t3_no_req2", 64'(bus.bus_req_o), 64'd0);

        // Bus error on 2nd beat of a 2-beat read
        need_read_i = 1'b1; reg_addr = 32'h3000; reg_size = 8'd8;
        tick();
        chk("t4_ask", 64'(rd_state_r), 64'(RD_ASK));
        bus.bus_gnt_i = 1'b1;
        tick();
        bus.bus_gnt_i = 1'b0;
        chk("t4_granted", 64'(rd_state_r), 64'(RD_GRANTED));
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 64'h11111111_22222222;
        tick();
        chk("t4_beat0", 64'(rd_state_r), 64'(RD_GRANTED));
        bus.bus_err_i = 1'b1; bus.bus_rdata_i = 64'hAAAAAAAA_BBBBBBBB;
        settle();
        chk("t4_next_err", 64'(rd_state_next_s), 64'(RD_ERROR));
        tick();
        bus.bus_rvalid_i = 1'b0; bus.bus_err_i = 1'b0;
        chk("t4_state_err", 64'(rd_state_r), 64'(RD_ERROR));
        chk("t4_err_hi", 64'(rd_state_error), 64'd1);
        chk("t4_req_lo", 64'(bus.bus_req_o), 64'd0);
        e = '0; e[0] = 32'h22222222; e[1] = 32'h11111111;
        chk_data("t4_partial", e);
        settle();
        chk("t4_no_accept", 64'(rd_state_next_s), 64'(RD_IDLE));
        tick();
        need_read_i = 1'b0;
        chk("t4_idle", 64'(rd_state_r), 64'(RD_IDLE));
        chk("t4_err_lo", 64'(rd_state_error), 64'd0);

        // Back-to-back, minimum-latency first read
        need_read_i = 1'b1; reg_addr = 32'h5000; reg_size = 8'd3;
        tick();
        bus.bus_gnt_i = 1'b1;
        tick();
        bus.bus_gnt_i = 1'b0;
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 64'h55555555_66666666;
        reg_addr = 32'h6000;
        tick();
        bus.bus_rvalid_i = 1'b0;
        chk("t5_idle_3edges", 64'(rd_state_r), 64'(RD_IDLE));
        e = '0; e[0] = 32'h66666666; e[1] = 32'h55555555;
        chk_data("t5_data1", e);
        settle();
        chk("t5_next_ask", 64'(rd_state_next_s), 64'(RD_ASK));
        tick();
        chk("t5_ask2", 64'(rd_state_r), 64'(RD_ASK));
        chk("t5_addr2", 64'(bus.bus_addr_o), 64'h6000);
        chk("t5_req2", 64'(bus.bus_req_o), 64'd1);
        e = '0;
        chk_data("t5_clr", e);
        bus.bus_gnt_i = 1'b1;
        tick();
        bus.bus_gnt_i = 1'b0;
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 64'h77777777_88888888;
        need_read_i = 1'b0;
        tick();
        bus.bus_rvalid_i = 1'b0;
        chk("t5_idle2", 64'(rd_state_r), 64'(RD_IDLE));
        e[0] = 32'h88888888; e[1] = 32'h77777777;
        chk_data("t5_data2", e);

        // Reset mid-operation
        need_read_i = 1'b1; reg_addr = 32'h9000; reg_size = 8'd9;
        tick();
        chk("t6_ask", 64'(rd_state_r), 64'(RD_ASK));
        need_read_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        chk("t6_state", 64'(rd_state_r), 64'(RD_IDLE));
        chk("t6_req", 64'(bus.bus_req_o), 64'd0);
        chk("t6_addr", 64'(bus.bus_addr_o), 64'd0);
        chk("t6_size", 64'(bus.bus_size_o), 64'd0);
        e = '0;
        chk_data("t6_data", e);
        reset_n_i = 1'b1;
        tick();
        chk("t6_idle", 64'(rd_state_r), 64'(RD_IDLE));

`ifdef CODMA_RD_TIMEOUT_EN
        // Grant never arrives
        need_read_i = 1'b1; reg_addr = 32'hA000; reg_size = 8'd3;
        tick();
        chk("t7_ask", 64'(rd_state_r), 64'(RD_ASK));
        repeat (TMO - 1) tick();
        chk("t7_still_ask", 64'(rd_state_r), 64'(RD_ASK));
        chk("t7_err_lo", 64'(rd_state_error), 64'd0);
        tick();
        chk("t7_err_hi", 64'(rd_state_error), 64'd1);
        chk("t7_req_lo", 64'(bus.bus_req_o), 64'd0);
        need_read_i = 1'b0;
        tick();
        chk("t7_idle", 64'(rd_state_r), 64'(RD_IDLE));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
